// File: rtl/pixel_array_sequencer.sv
// Frame sequencer for the pixel array: global erase, timed expose, then row-by-row readout.
// Optional ROW_TIMEOUT_EN adds a per-row row_done watchdog with a sticky error flag.
module pixel_array_sequencer #(
    parameter int ROWS           = 3,
    parameter int WIDTH          = 2,
    parameter int ERASE_CYCLES   = 4,
    parameter int EXPOSE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             row_done,
    output logic             erase,
    output logic             expose,
    output logic             adc_enable,
    output logic [WIDTH:0]   decoder_select,
    output logic             row_strobe,
    output logic             frame_done,
    output logic             busy,
    output logic             error
);

    localparam int PH_MAX = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [PH_W-1:0]  ERASE_LAST  = PH_W'(ERASE_CYCLES);
    localparam logic [PH_W-1:0]  EXPOSE_LAST = PH_W'(EXPOSE_CYCLES);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [PH_W-1:0]   ph_cnt, ph_cnt_n;
    logic [ROW_W-1:0]  row, row_n;
    logic              strobe_n;

    function automatic logic [WIDTH:0] to_sel(input logic [ROW_W-1:0] r);
        logic [WIDTH:0] s;
        s = '0;
        s[ROW_W-1:0] = r;
        return s;
    endfunction

`ifdef ROW_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wait_cnt, wait_n;
    logic          err_n;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
    assign error      = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        ph_cnt_n = ph_cnt;
        row_n    = row;
        strobe_n = 1'b0;
`ifdef ROW_TIMEOUT_EN
        wait_n   = wait_cnt;
        err_n    = error;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_ERASE;
                    ph_cnt_n = PH_W'(1);
                    row_n    = '0;
`ifdef ROW_TIMEOUT_EN
                    err_n    = 1'b0;
`endif
                end
            end
            S_ERASE: begin
                if (abort) begin
                    state_n  = S_IDLE;
                    ph_cnt_n = '0;
                end else if (ph_cnt == ERASE_LAST) begin
                    state_n  = S_EXPOSE;
                    ph_cnt_n = PH_W'(1);
                end else begin
                    ph_cnt_n = ph_cnt + 1'b1;
                end
            end
            S_EXPOSE: begin
                if (abort) begin
                    state_n  = S_IDLE;
                    ph_cnt_n = '0;
                end else if (ph_cnt == EXPOSE_LAST) begin
                    state_n  = S_CONVERT;
                    ph_cnt_n = '0;
                    row_n    = '0;
`ifdef ROW_TIMEOUT_EN
                    wait_n   = '0;
`endif
                end else begin
                    ph_cnt_n = ph_cnt + 1'b1;
                end
            end
            S_CONVERT: begin
                // abort wins over a same-cycle row_done, so no strobe is issued
                if (abort) begin
                    state_n = S_IDLE;
                    row_n   = '0;
                end else if (row_done) begin
                    state_n  = S_GAP;
                    strobe_n = 1'b1;
                end
`ifdef ROW_TIMEOUT_EN
                else if (wait_cnt == TMO_LAST) begin
                    state_n = S_IDLE;
                    row_n   = '0;
                    err_n   = 1'b1;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
`endif
            end
            S_GAP: begin
                if (abort) begin
                    state_n = S_IDLE;
                    row_n   = '0;
                end else if (row == ROW_LAST) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_CONVERT;
                    row_n   = row + 1'b1;
`ifdef ROW_TIMEOUT_EN
                    wait_n  = '0;
`endif
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                row_n   = '0;
            end
            default: begin
                state_n  = S_IDLE;
                ph_cnt_n = '0;
                row_n    = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            ph_cnt         <= '0;
            row            <= '0;
            erase          <= 1'b0;
            expose         <= 1'b0;
            adc_enable     <= 1'b0;
            decoder_select <= '0;
            row_strobe     <= 1'b0;
            frame_done     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            ph_cnt         <= ph_cnt_n;
            row            <= row_n;
            erase          <= (state_n == S_ERASE);
            expose         <= (state_n == S_EXPOSE);
            adc_enable     <= (state_n == S_CONVERT);
            decoder_select <= ((state_n == S_CONVERT) || (state_n == S_GAP)) ? to_sel(row_n) : '0;
            row_strobe     <= strobe_n;
            frame_done     <= (state_n == S_DONE);
            busy           <= (state_n != S_IDLE);
        end
    end

`ifdef ROW_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            error    <= 1'b0;
        end else begin
            wait_cnt <= wait_n;
            error    <= err_n;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_array_sequencer.sv
// Scoreboard bench for pixel_array_sequencer: stimulus queues expected row/frame events,
// a negedge monitor pops and compares them; phase lengths and control are checked inline.
module tb_pixel_array_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       row_done = 1'b0;
    logic       erase, expose, adc_enable, row_strobe, frame_done, busy, error;
    logic [2:0] decoder_select;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // kind 1 = row_strobe, kind 2 = frame_done; sel = decoder_select seen with it
    typedef struct {
        int kind;
        int sel;
    } ev_t;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    pixel_array_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .row_done       (row_done),
        .erase          (erase),
        .expose         (expose),
        .adc_enable     (adc_enable),
        .decoder_select (decoder_select),
        .row_strobe     (row_strobe),
        .frame_done     (frame_done),
        .busy           (busy),
        .error          (error)
    );

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act == req) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endfunction

    function automatic void push_ev(int kind, int sel);
        ev_t e;
        e.kind = kind;
        e.sel  = sel;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin : monitor
        ev_t e;
        int  kind;
        kind = (frame_done ? 2 : 0) + (row_strobe ? 1 : 0);
        if (reset && kind != 0) begin
            if (exp_q.size() == 0) check("unexpected_event", kind, 0);
            else begin
                e = exp_q.pop_front();
                check("event_kind", kind, e.kind);
                check("event_sel", int'(decoder_select), e.sel);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic measure(input int which, output int n);
        n = 0;
        while (((which == 0) ? erase : expose) && n < 100) begin
            check("erase_expose_excl", int'(erase & expose), 0);
            n++;
            tick();
        end
    endtask

    task automatic wait_adc();
        int n = 0;
        while (!adc_enable && n < 100) begin
            tick();
            n++;
        end
        if (!adc_enable) check("wait_adc_timeout", int'(adc_enable), 1);
    endtask

    // Three CONVERT cycles per row, row_done on the third.
    task automatic nominal_readout();
        for (int r = 0; r < 3; r++) begin
            check("conv_adc", int'(adc_enable), 1);
            check("conv_sel", int'(decoder_select), r);
            row_done = 1'b0;
            tick();
            tick();
            row_done = 1'b1;
            push_ev(1, r);
            tick();
            row_done = 1'b0;
            check("gap_adc", int'(adc_enable), 0);
            check("gap_sel", int'(decoder_select), r);
            if (r == 2) push_ev(2, 0);
            tick();
        end
        check("done_busy", int'(busy), 1);
        tick();
        check("after_done_busy", int'(busy), 0);
    endtask

    task automatic instant_readout(output int n);
        for (int r = 0; r < 3; r++) push_ev(1, r);
        push_ev(2, 0);
        row_done = 1'b1;
        n = 0;
        while (!frame_done && n < 50) begin
            tick();
            n++;
        end
    endtask

    initial begin : stim
        int n;
        int fd;

        repeat (3) tick();
        check("reset_outputs",
              int'({erase, expose, adc_enable, decoder_select, row_strobe, frame_done, busy, error}), 0);
        reset = 1'b1;
        tick();
        tick();
        check("idle_no_start", int'(busy), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("abort_in_idle", int'(busy), 0);

        // nominal frame
        pulse_start();
        measure(0, n);
        check("nom_erase_len", n, 4);
        measure(1, n);
        check("nom_expose_len", n, 8);
        nominal_readout();
        check("nom_queue_empty", exp_q.size(), 0);

        // instant row_done
        pulse_start();
        measure(0, n);
        measure(1, n);
        check("inst_adc_first", int'(adc_enable), 1);
        instant_readout(n);
        check("inst_readout_len", n, 6);
        row_done = 1'b0;
        tick();
        check("inst_idle", int'(busy), 0);
        check("inst_queue_empty", exp_q.size(), 0);

        // start held high across two frames
        row_done = 1'b0;
        start = 1'b1;
        tick();
        measure(0, n);
        check("held_erase_len", n, 4);
        measure(1, n);
        check("held_expose_len", n, 8);
        instant_readout(n);
        check("held_readout_len", n, 6);
        tick();
        check("held_idle_gap", int'(busy), 0);
        tick();
        check("held_restart", int'(erase), 1);
        start = 1'b0;
        measure(0, n);
        check("held2_erase_len", n, 4);
        measure(1, n);
        check("held2_expose_len", n, 8);
        instant_readout(n);
        check("held2_readout_len", n, 6);
        row_done = 1'b0;
        tick();
        tick();
        check("held_stays_idle", int'(busy), 0);
        check("held_queue_empty", exp_q.size(), 0);

        // abort with row_done high in row 1
        pulse_start();
        wait_adc();
        push_ev(1, 0);
        row_done = 1'b1;
        tick();
        row_done = 1'b0;
        tick();
        check("abort_row1_sel", int'(decoder_select), 1);
        row_done = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        row_done = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_strobe", int'(row_strobe), 0);
        check("abort_drives", int'({adc_enable, decoder_select}), 0);
        fd = 0;
        repeat (10) begin
            tick();
            if (frame_done) fd++;
        end
        check("abort_no_frame_done", fd, 0);
        check("abort_queue_empty", exp_q.size(), 0);

        // async reset mid-expose
        pulse_start();
        n = 0;
        while (!expose && n < 100) begin
            tick();
            n++;
        end
        tick();
        tick();
        #2 reset = 1'b0;
        #1 check("async_reset_outputs",
                 int'({erase, expose, adc_enable, decoder_select, row_strobe, frame_done, busy, error}), 0);
        tick();
        reset = 1'b1;
        tick();
        check("post_reset_idle", int'(busy), 0);
        pulse_start();
        measure(0, n);
        check("post_reset_erase_len", n, 4);
        measure(1, n);
        check("post_reset_expose_len", n, 8);
        nominal_readout();
        check("post_reset_queue_empty", exp_q.size(), 0);

`ifdef ROW_TIMEOUT_EN
        pulse_start();
        wait_adc();
        row_done = 1'b0;
        n = 0;
        while (!error && n < 200) begin
            tick();
            n++;
        end
        check("timeout_len", n, 64);
        check("timeout_idle", int'(busy), 0);
        pulse_start();
        check("error_cleared", int'(error), 0);
        measure(0, n);
        measure(1, n);
        nominal_readout();
        check("timeout_queue_empty", exp_q.size(), 0);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
